regfile_writeback_scheduler: RTL
================================

Name: regfile_writeback_scheduler

Overview:
- Shares the single write port of the 64 x 64-bit register file between two writeback sources: the ALU and the memory-load path.
- Each source has its own small queue.
- Queued writes drain to the register file one per cycle, in strict arrival order.
- Exports a pending-write mask so issue logic can stall on read-after-write hazards until a queued write has reached the register file.

Parameters:
- DATA_W, 64, width of write data.
- ADR_W, 6, width of register address (2**ADR_W registers).
- DEPTH, 2, entries per source queue (power of 2, >=2).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- aluValid  input  1  ALU writeback request.
- aluAdr  input  ADR_W  ALU destination register.
- aluData  input  DATA_W  ALU result.
- aluReady  output  1  ALU queue can accept.
- memValid  input  1  load writeback request.
- memAdr  input  ADR_W  load destination register.
- memData  input  DATA_W  load data.
- memReady  output  1  load queue can accept.
- writeAdr  output  ADR_W  to register file writeAdr.
- writeData  output  DATA_W  to register file writeData.
- writeEnable  output  1  to register file writeEnable.
- writeSrc  output  1  source of current write (0 = ALU, 1 = mem).
- pendingMask  output  2**ADR_W  bit i set while a write to register i is queued or being presented.

Behaviour:
- Reset (async, immediate):
  - Both queues and the order queue are emptied.
  - writeEnable=0, writeAdr=0, writeData=0, writeSrc=0, pendingMask=0.
  - aluReady=memReady=1 from the first cycle after reset deasserts.
- Accept rules:
  - Source X is accepted at a rising edge when xValid && xReady.
  - xReady = !full(X queue). It is a function of registered state only; no combinational path from any valid input.
  - Valid while not ready is ignored. The source must hold its request; nothing is dropped internally.
- Order queue:
  - A 2*DEPTH-entry FIFO of 1-bit source tags, pushed on every accept.
  - When ALU and mem are accepted on the same edge, the ALU tag is pushed first.
- Drain, one per cycle:
  - If the order queue is non-empty, its head tag selects the source.
  - That source's queue head is popped into registered output stage (writeAdr, writeData, writeSrc), and writeEnable=1 for exactly that cycle.
  - If the order queue is empty, writeEnable=0 and writeAdr/writeData/writeSrc hold their previous values.
- Latency:
  - An entry accepted at edge N into empty queues is presented with writeEnable=1 during cycle N+1..N+2.
  - The register file captures it at edge N+2.
  - There is no bypass from input to output.
- Throughput: sustains one write per cycle. Two sources sending every cycle fill the queues; readies then throttle to 1 accept per cycle in total.
- Ordering:
  - Writes leave in global arrival order.
  - Two writes to the same register therefore land in arrival order; same-edge ties resolve ALU then mem, so mem's value is final.
- Simultaneous push and pop on a full queue:
  - Ready is computed before the pop, so a full queue deasserts ready even if it is popping this cycle.
  - This is intentional, for timing isolation.
- pendingMask:
  - OR over all valid queue entries plus the output stage when writeEnable=1, decoded by address.
  - Combinational from registered state.
  - The bit clears in the cycle after the last write to that address is presented.
- Counters/pointers wrap modulo DEPTH (source queues) and 2*DEPTH (order queue). Full/empty use an extra wrap bit.
- Reset mid-operation: all queued writes are discarded without reaching the register file. If asserted during a writeEnable cycle, writeEnable falls immediately.

Test Plan:
- Single ALU write (aluAdr=5, aluData=0x1234) at edge 1, both queues empty:
  - writeEnable=1 with writeAdr=5, writeData=0x1234, writeSrc=0 during cycle after edge 2 only.
  - pendingMask[5]=1 from edge 1 until edge 3.
- Same edge, ALU (adr 7, data 0xA) and mem (adr 7, data 0xB):
  - Consecutive writes presented in order 0xA (src 0), then 0xB (src 1).
  - pendingMask[7] stays set through both; register 7 ends at 0xB.
- Both sources valid every cycle for 10 cycles with incrementing data:
  - aluReady/memReady deassert after queues fill.
  - Output writes one per cycle, in exact arrival order, none lost or duplicated.
  - All 20 writes are eventually presented once valids are held until accepted.
- Mem valid held with memReady forced low by a full mem queue (DEPTH=2) and the ALU idle:
  - No accept until a pop frees a slot.
  - The held request is accepted exactly once.
- Reset asserted asynchronously mid-burst while writeEnable=1:
  - writeEnable, pendingMask and writeAdr drop to 0 before the next edge.
  - After release, ready=1 and no stale write appears.
- Idle for 5 cycles after a write to adr 63:
  - writeEnable=0 and writeAdr holds 63.
  - pendingMask=0.

Source files
------------

// File: rtl/regfile_writeback_scheduler_if.sv
// Writeback request/response bundle between the ALU/load sources, the
// scheduler and the register-file write port.
interface regfile_writeback_scheduler_if #(
  parameter int DATA_W = 64,
  parameter int ADR_W  = 6
);
  logic                  aluValid;
  logic [ADR_W-1:0]      aluAdr;
  logic [DATA_W-1:0]     aluData;
  logic                  aluReady;
  logic                  memValid;
  logic [ADR_W-1:0]      memAdr;
  logic [DATA_W-1:0]     memData;
  logic                  memReady;
  logic [ADR_W-1:0]      writeAdr;
  logic [DATA_W-1:0]     writeData;
  logic                  writeEnable;
  logic                  writeSrc;
  logic [2**ADR_W-1:0]   pendingMask;

  modport master (
    output aluValid, aluAdr, aluData, memValid, memAdr, memData,
    input  aluReady, memReady, writeAdr, writeData, writeEnable, writeSrc,
           pendingMask
  );

  modport slave (
    input  aluValid, aluAdr, aluData, memValid, memAdr, memData,
    output aluReady, memReady, writeAdr, writeData, writeEnable, writeSrc,
           pendingMask
  );
endinterface

// File: rtl/regfile_writeback_scheduler.sv
// Arbitrates ALU and load writebacks onto the single register-file write port
// in global arrival order, and exports a pending-write hazard mask.
module regfile_writeback_scheduler #(
  parameter int DATA_W = 64,
  parameter int ADR_W  = 6,
  parameter int DEPTH  = 2
) (
  input logic clk,
  input logic reset,
  regfile_writeback_scheduler_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int OI   = PW + 1;
  localparam int NREG = 2**ADR_W;
  localparam logic [PW:0] QONE = 1;
  localparam logic [OI:0] OZERO = '0;

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [ADR_W-1:0]  r_aluAdr [DEPTH];
  logic [DATA_W-1:0] r_aluDat [DEPTH];
  logic [ADR_W-1:0]  r_memAdr [DEPTH];
  logic [DATA_W-1:0] r_memDat [DEPTH];
  logic [PW:0]       r_aluWr, r_aluRd, r_memWr, r_memRd;

  src_e              r_ord [2*DEPTH];
  logic [OI:0]       r_ordWr, r_ordRd;

  logic [ADR_W-1:0]  r_wAdr;
  logic [DATA_W-1:0] r_wDat;
  logic              r_wEn;
  src_e              r_wSrc;

  logic              w_aluFull, w_memFull, w_aluPush, w_memPush;
  logic              w_ordEmpty, w_aluPop, w_memPop;
  src_e              w_headSrc;
  logic [OI-1:0]     w_ordMemIdx;
  logic [ADR_W-1:0]  w_popAdr;
  logic [DATA_W-1:0] w_popDat;
  logic [NREG-1:0]   w_pend;

  function automatic logic slot_occ(input logic [PW-1:0] slot,
                                    input logic [PW:0] wr,
                                    input logic [PW:0] rd);
    logic [PW:0]   cnt;
    logic [PW-1:0] off;
    cnt = wr - rd;
    off = slot - rd[PW-1:0];
    return {1'b0, off} < cnt;
  endfunction

  assign w_aluFull = (r_aluWr[PW] != r_aluRd[PW]) && (r_aluWr[PW-1:0] == r_aluRd[PW-1:0]);
  assign w_memFull = (r_memWr[PW] != r_memRd[PW]) && (r_memWr[PW-1:0] == r_memRd[PW-1:0]);
  assign w_aluPush = bus.aluValid && !w_aluFull;
  assign w_memPush = bus.memValid && !w_memFull;

  assign w_ordEmpty  = (r_ordWr == r_ordRd);
  assign w_headSrc   = r_ord[r_ordRd[OI-1:0]];
  assign w_aluPop    = !w_ordEmpty && (w_headSrc == SRC_ALU);
  assign w_memPop    = !w_ordEmpty && (w_headSrc == SRC_MEM);
  // Same-edge accepts: ALU tag takes the write slot, mem tag the next one.
  assign w_ordMemIdx = r_ordWr[OI-1:0] + {{(OI-1){1'b0}}, w_aluPush};

  always_comb begin
    w_popAdr = r_aluAdr[r_aluRd[PW-1:0]];
    w_popDat = r_aluDat[r_aluRd[PW-1:0]];
    if (w_headSrc == SRC_MEM) begin
      w_popAdr = r_memAdr[r_memRd[PW-1:0]];
      w_popDat = r_memDat[r_memRd[PW-1:0]];
    end
  end

  // Payload and tag storage need no reset; occupancy is tracked by pointers.
  always_ff @(posedge clk) begin
    if (w_aluPush) begin
      r_aluAdr[r_aluWr[PW-1:0]] <= bus.aluAdr;
      r_aluDat[r_aluWr[PW-1:0]] <= bus.aluData;
      r_ord[r_ordWr[OI-1:0]]    <= SRC_ALU;
    end
    if (w_memPush) begin
      r_memAdr[r_memWr[PW-1:0]] <= bus.memAdr;
      r_memDat[r_memWr[PW-1:0]] <= bus.memData;
      r_ord[w_ordMemIdx]        <= SRC_MEM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aluWr <= '0;
      r_aluRd <= '0;
      r_memWr <= '0;
      r_memRd <= '0;
      r_ordWr <= '0;
      r_ordRd <= '0;
      r_wEn   <= 1'b0;
      r_wAdr  <= '0;
      r_wDat  <= '0;
      r_wSrc  <= SRC_ALU;
    end else begin
      if (w_aluPush) r_aluWr <= r_aluWr + QONE;
      if (w_memPush) r_memWr <= r_memWr + QONE;
      if (w_aluPop)  r_aluRd <= r_aluRd + QONE;
      if (w_memPop)  r_memRd <= r_memRd + QONE;
      r_ordWr <= r_ordWr + {OZERO[OI:1], w_aluPush} + {OZERO[OI:1], w_memPush};
      if (!w_ordEmpty) begin
        r_ordRd <= r_ordRd + {OZERO[OI:1], 1'b1};
        r_wEn   <= 1'b1;
        r_wAdr  <= w_popAdr;
        r_wDat  <= w_popDat;
        r_wSrc  <= w_headSrc;
      end else begin
        r_wEn   <= 1'b0;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_occ(PW'(i), r_aluWr, r_aluRd)) w_pend[r_aluAdr[i]] = 1'b1;
      if (slot_occ(PW'(i), r_memWr, r_memRd)) w_pend[r_memAdr[i]] = 1'b1;
    end
    if (r_wEn) w_pend[r_wAdr] = 1'b1;
  end

  assign bus.aluReady    = !w_aluFull;
  assign bus.memReady    = !w_memFull;
  assign bus.writeAdr    = r_wAdr;
  assign bus.writeData   = r_wDat;
  assign bus.writeEnable = r_wEn;
  assign bus.writeSrc    = r_wSrc;
  assign bus.pendingMask = w_pend;
endmodule
